alu_issue_regfile: RTL and testbench
====================================

Name: alu_issue_regfile

Overview:
- Issue stage directly upstream of the 4-bit Decode_And_Execute ALU.
- Accepts packed instructions over a valid/ready handshake and reads two source operands from a small register file.
- Drives the ALU's rs/rt/sel inputs from registers, then writes the ALU's rd result back to a destination register.
- Also provides a host load port for initialising registers, a debug read port and a retired-instruction counter.

Parameters:
DATA_W, 4, operand/result width; must match the ALU.
ADDR_W, 2, register address width; register file holds 2**ADDR_W entries.
CNT_W, 8, retired-instruction counter width.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
instr_valid  input  1  instruction presented.
instr_ready  output  1  stage can accept an instruction.
instr  input  3+3*ADDR_W  packed as {sel[2:0], dst, srcA, srcB}; sel occupies the MSBs.
host_we  input  1  host register write strobe.
host_addr  input  ADDR_W  host write address.
host_data  input  DATA_W  host write data.
alu_rs  output  DATA_W  operand A to ALU, registered.
alu_rt  output  DATA_W  operand B to ALU, registered.
alu_sel  output  3  ALU opcode, registered.
alu_rd  input  DATA_W  ALU combinational result.
done  output  1  one-cycle pulse: an instruction retired on the previous edge.
result  output  DATA_W  value written by the last retired instruction.
dbg_addr  input  ADDR_W  debug read address.
dbg_data  output  DATA_W  combinational read of regs[dbg_addr].
retire_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; all regs=0.
  - alu_rs=alu_rt=0, alu_sel=0, done=0, result=0, retire_cnt=0.
  - IR (latched dst) cleared.
- FSM states: IDLE, EXEC.
  - instr_ready=1 only in IDLE (combinational from state).
- IDLE:
  - On instr_valid & instr_ready: latch alu_sel=instr.sel, alu_rs=regs[srcA], alu_rt=regs[srcB] and the dst field; go to EXEC.
  - Otherwise remain in IDLE; alu_* outputs hold their previous values.
- EXEC (exactly one cycle):
  - alu_rd is valid combinationally.
  - At the closing edge: regs[dst]<=alu_rd, result<=alu_rd, done<=1, retire_cnt<=retire_cnt+1; go to IDLE.
- Timing:
  - Latency: acceptance edge -> EXEC cycle -> writeback edge; done is high in the cycle after writeback.
  - Throughput: one instruction per 2 cycles. With instr_valid held high, the next instruction is accepted in the same cycle done is high.
- done is 0 in every cycle not immediately following an EXEC writeback.
- Operand reads at acceptance see all writes completed on earlier edges. An instruction reading the previous instruction's dst always gets the new value; no stall is needed.
- Host write:
  - Honoured on any edge.
  - If host_we coincides with acceptance and host_addr equals a source, the operand receives the OLD value; the register still updates.
  - If host_we coincides with EXEC writeback to the same address, the ALU writeback wins and the host write is dropped. A different address lets both writes happen.
- retire_cnt wraps modulo 2**CNT_W (255 -> 0); host writes do not count.
- Arithmetic is performed entirely by the ALU; this block stores alu_rd unmodified at DATA_W bits.
- instr is sampled only at acceptance; changes while instr_ready=0 are ignored.
- rst asserted in EXEC: the pending writeback is aborted; no register changes other than the reset values; done stays 0.

Test Plan:
- Host writes r0=5, r1=3, then issue {sel=000, dst=2, srcA=0, srcB=1} -> alu_rs=5, alu_rt=3, alu_sel=000 during EXEC; next cycle done=1, result=2, dbg_data(r2)=2, retire_cnt=1.
- r0=9, r1=9, sel=001 into r3 -> result=4'b0010 (wrap); then sel=110 with r0=2, r1=7 into r2 -> result=4'b1011.
- Hold instr_valid=1 with two instructions: instr_ready pattern 1,0,1,0; the second, reading the first's dst, sees the updated value; done pulses one cycle each.
- Host write r1=7 on the acceptance edge of an instruction reading r1 (old value 3) -> alu_rt=3, r1 afterwards=7. Host write to dst on the writeback edge -> ALU value kept.
- Assert rst during EXEC -> no writeback, done=0, regs=0, retire_cnt=0, instr_ready=1 on the next cycle.
- Retire 256 instructions -> retire_cnt returns to 0 and done pulses 256 times.

Source files
------------

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: issue stage sitting directly in front of the 4-bit
// Decode_And_Execute ALU.
//
// It accepts one packed instruction at a time over a valid/ready handshake. On
// acceptance it reads both source operands from a small register file and
// registers them, together with the opcode, onto the ALU inputs. One cycle
// later it writes the ALU's combinational result back to the destination
// register.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   instr_valid      instruction presented
//   instr_ready      stage can accept (high only in IDLE)
//   instr            {sel[2:0], dst, src_a, src_b}
//   host_we/addr/data  host register write port, honoured on any edge
//   alu_rs/rt/sel    registered operands and opcode driven to the ALU
//   alu_rd           combinational ALU result, consumed during EXEC
//   done             one-cycle pulse after each writeback
//   result           value written by the most recently retired instruction
//   dbg_addr/data    combinational debug read of the register file
//   retire_cnt       retired-instruction counter, wraps modulo 2**CNT_W
module alu_issue_regfile #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3+3*ADDR_W-1:0] instr,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_data,
  output logic [DATA_W-1:0]     alu_rs,
  output logic [DATA_W-1:0]     alu_rt,
  output logic [2:0]            alu_sel,
  input  logic [DATA_W-1:0]     alu_rd,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    StIdle,
    StExec
  } state_e;

  state_e state_q, state_d;

  // Register file and pipeline state.
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  logic [DATA_W-1:0] alu_rs_q, alu_rs_d;
  logic [DATA_W-1:0] alu_rt_q, alu_rt_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  // Instruction field decode.
  logic [2:0]        instr_sel;
  logic [ADDR_W-1:0] instr_dst;
  logic [ADDR_W-1:0] instr_src_a;
  logic [ADDR_W-1:0] instr_src_b;

  assign instr_sel   = instr[3+3*ADDR_W-1 -: 3];
  assign instr_dst   = instr[3*ADDR_W-1 -: ADDR_W];
  assign instr_src_a = instr[2*ADDR_W-1 -: ADDR_W];
  assign instr_src_b = instr[ADDR_W-1:0];

  logic accept;

  assign instr_ready = (state_q == StIdle);
  assign accept      = instr_valid & instr_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: begin
        // The ALU is purely combinational, so EXEC always lasts one cycle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d       = regs_q;
    alu_rs_d     = alu_rs_q;
    alu_rt_d     = alu_rt_q;
    alu_sel_d    = alu_sel_q;
    dst_d        = dst_q;
    done_d       = 1'b0;
    result_d     = result_q;
    retire_cnt_d = retire_cnt_q;

    if (host_we) begin
      regs_d[host_addr] = host_data;
    end

    // Operands come from regs_q, so a host write on the acceptance edge is
    // not forwarded: the instruction sees the old value.
    if (accept) begin
      alu_sel_d = instr_sel;
      alu_rs_d  = regs_q[instr_src_a];
      alu_rt_d  = regs_q[instr_src_b];
      dst_d     = instr_dst;
    end

    // Assigned after the host write so the ALU writeback wins on a collision.
    if (state_q == StExec) begin
      regs_d[dst_q] = alu_rd;
      result_d      = alu_rd;
      done_d        = 1'b1;
      retire_cnt_d  = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q       <= '{default: '0};
      alu_rs_q     <= '0;
      alu_rt_q     <= '0;
      alu_sel_q    <= '0;
      dst_q        <= '0;
      done_q       <= 1'b0;
      result_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      alu_rs_q     <= alu_rs_d;
      alu_rt_q     <= alu_rt_d;
      alu_sel_q    <= alu_sel_d;
      dst_q        <= dst_d;
      done_q       <= done_d;
      result_q     <= result_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_rs     = alu_rs_q;
  assign alu_rt     = alu_rt_q;
  assign alu_sel    = alu_sel_q;
  assign done       = done_q;
  assign result     = result_q;
  assign retire_cnt = retire_cnt_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_regfile.sv
// Directed testbench for alu_issue_regfile. A small behavioural stand-in
// drives alu_rd from alu_sel/alu_rs/alu_rt (000 sub, 001 add, 110 sub).
module tb_alu_issue_regfile;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 8;

  logic                  clk;
  logic                  rst;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [3+3*ADDR_W-1:0] instr;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_data;
  logic [DATA_W-1:0]     alu_rs;
  logic [DATA_W-1:0]     alu_rt;
  logic [2:0]            alu_sel;
  logic [DATA_W-1:0]     alu_rd;
  logic                  done;
  logic [DATA_W-1:0]     result;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_data;
  logic [CNT_W-1:0]      retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .alu_rs     (alu_rs),
    .alu_rt     (alu_rt),
    .alu_sel    (alu_sel),
    .alu_rd     (alu_rd),
    .done       (done),
    .result     (result),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_rd = '0;
    case (alu_sel)
      3'b000:  alu_rd = alu_rs - alu_rt;
      3'b001:  alu_rd = alu_rs + alu_rt;
      3'b110:  alu_rd = alu_rs - alu_rt;
      default: alu_rd = alu_rs ^ alu_rt;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; return 1 time unit after it, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] exp);
    dbg_addr = a;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    tick();
    host_we   = 1'b0;
  endtask

  task automatic set_instr(input logic [2:0] sel, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb);
    instr = {sel, dst, sa, sb};
  endtask

  int  pulses;
  logic saw255;

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    host_we     = 1'b0;
    host_addr   = '0;
    host_data   = '0;
    dbg_addr    = '0;
    tick();
    tick();

    // Reset state
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_cnt", 32'(retire_cnt), 0);
    check("rst_rs", 32'(alu_rs), 0);
    check("rst_sel", 32'(alu_sel), 0);
    dbg_check("rst_r3", 2'd3, 4'd0);
    rst = 1'b0;

    // Basic issue: r2 = r0 - r1 = 5 - 3
    host_write(2'd0, 4'd5);
    host_write(2'd1, 4'd3);
    dbg_check("host_r0", 2'd0, 4'd5);
    set_instr(3'b000, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("t1_rs", 32'(alu_rs), 5);
    check("t1_rt", 32'(alu_rt), 3);
    check("t1_sel", 32'(alu_sel), 0);
    check("t1_ready_exec", 32'(instr_ready), 0);
    check("t1_done_exec", 32'(done), 0);
    tick();
    check("t1_done", 32'(done), 1);
    check("t1_result", 32'(result), 2);
    check("t1_cnt", 32'(retire_cnt), 1);
    dbg_check("t1_r2", 2'd2, 4'd2);
    tick();
    check("t1_done_low", 32'(done), 0);

    // Add with wrap: 9 + 9 = 18 -> 2
    host_write(2'd0, 4'd9);
    host_write(2'd1, 4'd9);
    set_instr(3'b001, 2'd3, 2'd0, 2'd1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("t2_wrap", 32'(result), 2);
    // sel 110: 2 - 7 = -5 -> 4'b1011
    host_write(2'd0, 4'd2);
    host_write(2'd1, 4'd7);
    set_instr(3'b110, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("t2_sel110", 32'(result), 11);
    check("t2_cnt", 32'(retire_cnt), 3);

    // Back-to-back with valid held: r3 = 2 + 7 = 9, then r0 = r3 + r3 = 2
    set_instr(3'b001, 2'd3, 2'd0, 2'd1);
    instr_valid = 1'b1;
    check("b2b_ready0", 32'(instr_ready), 1);
    tick();
    check("b2b_ready1", 32'(instr_ready), 0);
    set_instr(3'b001, 2'd0, 2'd3, 2'd3);
    tick();
    check("b2b_ready2", 32'(instr_ready), 1);
    check("b2b_done_a", 32'(done), 1);
    check("b2b_result_a", 32'(result), 9);
    tick();
    instr_valid = 1'b0;
    check("b2b_ready3", 32'(instr_ready), 0);
    check("b2b_done_gap", 32'(done), 0);
    check("b2b_fwd_rs", 32'(alu_rs), 9);
    check("b2b_fwd_rt", 32'(alu_rt), 9);
    tick();
    check("b2b_done_b", 32'(done), 1);
    check("b2b_result_b", 32'(result), 2);
    dbg_check("b2b_r0", 2'd0, 4'd2);
    check("b2b_cnt", 32'(retire_cnt), 5);

    // Host write collides with acceptance: operand sees old r1 = 3
    host_write(2'd1, 4'd3);
    set_instr(3'b001, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    host_we     = 1'b1;
    host_addr   = 2'd1;
    host_data   = 4'd7;
    tick();
    instr_valid = 1'b0;
    check("hc_old_rt", 32'(alu_rt), 3);
    dbg_check("hc_r1_new", 2'd1, 4'd7);
    // Host write to dst on the writeback edge: ALU value (2 + 3 = 5) wins
    host_addr = 2'd2;
    host_data = 4'd15;
    tick();
    host_we = 1'b0;
    dbg_check("hc_alu_wins", 2'd2, 4'd5);
    // Different address on writeback: both land. r0 = 5 - 7 = 14, r3 = 6
    set_instr(3'b000, 2'd0, 2'd2, 2'd1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    host_we   = 1'b1;
    host_addr = 2'd3;
    host_data = 4'd6;
    tick();
    host_we = 1'b0;
    dbg_check("hc_both_r0", 2'd0, 4'd14);
    dbg_check("hc_both_r3", 2'd3, 4'd6);

    // Reset during EXEC aborts the writeback
    set_instr(3'b001, 2'd1, 2'd0, 2'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rx_done", 32'(done), 0);
    check("rx_ready", 32'(instr_ready), 1);
    check("rx_cnt", 32'(retire_cnt), 0);
    check("rx_result", 32'(result), 0);
    dbg_check("rx_r0", 2'd0, 4'd0);
    dbg_check("rx_r1", 2'd1, 4'd0);
    tick();
    check("rx_done_after", 32'(done), 0);

    // 256 retirements: counter wraps to 0
    pulses = 0;
    saw255 = 1'b0;
    set_instr(3'b001, 2'd0, 2'd0, 2'd0);
    instr_valid = 1'b1;
    for (int c = 0; c < 512; c++) begin
      tick();
      if (done) begin
        pulses++;
        if (pulses == 255) begin
          check("wrap_cnt255", 32'(retire_cnt), 255);
          saw255 = 1'b1;
        end
      end
    end
    instr_valid = 1'b0;
    check("wrap_saw255", 32'(saw255), 1);
    check("wrap_pulses", 32'(pulses), 256);
    check("wrap_cnt0", 32'(retire_cnt), 0);
    tick();
    check("wrap_done_end", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
